// File: rtl/full_sub_pkg.sv
// Shared constants for the full_sub ripple-borrow subtractor.
// Supported operand widths and the default width.
package full_sub_pkg;

  localparam int FS_WIDTH_MIN     = 1;
  localparam int FS_WIDTH_MAX     = 64;
  localparam int FS_WIDTH_DEFAULT = 1;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Latency: combinational, zero cycles.
// Backpressure: none, because the cell is a pure function.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // A borrow comes from b exceeding a, or from an incoming borrow when a equals b.
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_sub.sv
// Registered WIDTH-bit ripple-borrow subtractor: {barrow, diff} = a - b - cin.
// Latency: one clock from an accepted in_valid to out_valid.
// Backpressure: none; it accepts one operand set per cycle.
module full_sub
  import full_sub_pkg::*;
#(
  parameter int WIDTH = FS_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] diff,
  output logic             barrow,
  output logic             out_valid
);

  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] d_comb;

  assign borrow[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_sub_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (borrow[i]),
      .d    (d_comb[i]),
      .bout (borrow[i+1])
    );
  end

  // The result registers load only on valid input, so junk operands on idle
  // cycles never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff      <= '0;
      barrow    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff   <= d_comb;
        barrow <= borrow[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_sub.sv
// Directed self-checking bench for full_sub at WIDTH=1 and WIDTH=8.
module tb_full_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       a1, b1, cin1;
  logic       diff1, barrow1, vld1;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] diff8;
  logic       barrow8, vld8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a1), .b(b1), .cin(cin1),
    .diff(diff1), .barrow(barrow1), .out_valid(vld1)
  );

  full_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a8), .b(b8), .cin(cin8),
    .diff(diff8), .barrow(barrow8), .out_valid(vld8)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed 1-bit truth table, indexed by {a,b,cin}.
  logic [7:0] tt_d = 8'h96;
  logic [7:0] tt_b = 8'h8E;

  // 8-bit streaming vectors: a, b, cin, expected diff, expected borrow.
  logic [7:0] v_a [6] = '{8'h00, 8'h80, 8'h05, 8'hFF, 8'h3C, 8'h10};
  logic [7:0] v_b [6] = '{8'h00, 8'h01, 8'h05, 8'h00, 8'h3C, 8'h20};
  logic       v_c [6] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
  logic [7:0] v_d [6] = '{8'hFF, 8'h7F, 8'hFF, 8'hFF, 8'h00, 8'hF0};
  logic       v_w [6] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};

  initial begin
    // Reset with a valid operand present: outputs must stay cleared.
    rst = 1'b1; in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    a8 = 8'h01; b8 = 8'h00; cin8 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_diff1",   8'(diff1),   8'h00);
      chk("rst_barrow1", 8'(barrow1), 8'h00);
      chk("rst_vld1",    8'(vld1),    8'h00);
      chk("rst_diff8",   diff8,       8'h00);
      chk("rst_vld8",    8'(vld8),    8'h00);
    end
    rst = 1'b0;

    // Exhaustive 1-bit table, streamed back to back.
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin1} = 3'(i);
      in_valid = 1'b1;
      step();
      chk($sformatf("tt_diff_%0d", i),   8'(diff1),   8'(tt_d[i]));
      chk($sformatf("tt_barrow_%0d", i), 8'(barrow1), 8'(tt_b[i]));
      chk($sformatf("tt_vld_%0d", i),    8'(vld1),    8'h01);
    end

    // Hold: idle cycle with changed (and unknown) operands keeps the last result.
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0;
    step();
    chk("load_diff1", 8'(diff1), 8'h01);
    chk("load_diff8", diff8,     8'h7F);
    in_valid = 1'b0;
    a1 = 1'b0; b1 = 1'b1;
    a8 = 'x; b8 = 'x; cin8 = 1'bx;
    step();
    chk("hold_diff1",   8'(diff1),   8'h01);
    chk("hold_barrow1", 8'(barrow1), 8'h00);
    chk("hold_vld1",    8'(vld1),    8'h00);
    chk("hold_diff8",   diff8,       8'h7F);
    chk("hold_barrow8", 8'(barrow8), 8'h00);
    step();
    chk("hold2_diff8",  diff8,       8'h7F);

    // 8-bit wrap/ripple vectors on consecutive cycles.
    for (int k = 0; k < 6; k++) begin
      a8 = v_a[k]; b8 = v_b[k]; cin8 = v_c[k];
      in_valid = 1'b1;
      step();
      chk($sformatf("w8_diff_%0d", k),   diff8,       v_d[k]);
      chk($sformatf("w8_barrow_%0d", k), 8'(barrow8), 8'(v_w[k]));
      chk($sformatf("w8_vld_%0d", k),    8'(vld8),    8'h01);
    end

    // Reset on the same edge as a valid input discards that result.
    rst = 1'b1; in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1;
    step();
    chk("mid_rst_diff1",   8'(diff1),   8'h00);
    chk("mid_rst_barrow1", 8'(barrow1), 8'h00);
    chk("mid_rst_vld1",    8'(vld1),    8'h00);
    chk("mid_rst_diff8",   diff8,       8'h00);
    chk("mid_rst_barrow8", 8'(barrow8), 8'h00);
    rst = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b1;
    a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0;
    step();
    chk("post_rst_diff1",   8'(diff1),   8'h01);
    chk("post_rst_barrow1", 8'(barrow1), 8'h01);
    chk("post_rst_vld1",    8'(vld1),    8'h01);
    chk("post_rst_diff8",   diff8,       8'h7F);
    chk("post_rst_barrow8", 8'(barrow8), 8'h00);
    in_valid = 1'b0;
    step();
    chk("idle_vld8", 8'(vld8), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
